// File: rtl/reg2ram.sv
// reg2ram: snapshot engine.
//   On write_trigger the REG_NUM x 32-bit vector seq_reg is captured into a
//   shadow register and written as REG_NUM consecutive words into a dual-port
//   RAM starting at write_addr (port A). The AXI register port reads and
//   writes the same RAM through port B.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   seq_reg          source vector, word i = seq_reg[32*i+31:32*i]
//   write_addr       RAM base word address, sampled with write_trigger
//   write_trigger    start a snapshot
//   write_busy       snapshot in progress
//   write_done       one-cycle pulse after the last word is committed
//   write_drop       one-cycle pulse: trigger arrived while busy, ignored
//   reg_readdata     AXI read data (port B, 1-cycle latency)
//   reg_writedata    AXI write data
//   reg_rd, reg_wr   AXI requests, held until reg_ready
//   reg_ready        AXI handshake, toggles while a request is held
//   reg_addr         AXI word address

// Simple dual-port RAM. Port A is write-only here; port B reads and writes.
// PIPELINE=0 gives a 1-clock read latency on port B, PIPELINE!=0 adds a stage.
module generic_dpram #(
  parameter int DW       = 32,
  parameter int AW       = 4,
  parameter int PIPELINE = 0
) (
  input  logic          clk,
  input  logic [AW-1:0] address_a,
  input  logic [DW-1:0] data_a,
  input  logic          wren_a,
  input  logic [AW-1:0] address_b,
  input  logic [DW-1:0] data_b,
  input  logic          wren_b,
  input  logic          rden_b,
  output logic [DW-1:0] q_b
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;

  // Read returns the pre-write contents on a same-edge read/write.
  always_ff @(posedge clk) begin
    if (wren_a) mem[address_a] <= data_a;
    if (wren_b) mem[address_b] <= data_b;
    if (rden_b) rd_q <= mem[address_b];
  end

  generate
    if (PIPELINE != 0) begin : g_pipe
      logic [DW-1:0] q_pipe;
      always_ff @(posedge clk) q_pipe <= rd_q;
      assign q_b = q_pipe;
    end else begin : g_nopipe
      assign q_b = rd_q;
    end
  endgenerate
endmodule

module reg2ram #(
  parameter  int REG_NUM = 10,
  parameter  int BUF_NUM = 80,
  localparam int aw      = $clog2(REG_NUM*BUF_NUM),
  localparam int sw      = $clog2(REG_NUM+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_NUM*32-1:0] seq_reg,
  input  logic [aw-1:0]        write_addr,
  input  logic                 write_trigger,
  output logic                 write_busy,
  output logic                 write_done,
  output logic                 write_drop,
  output logic [31:0]          reg_readdata,
  input  logic [31:0]          reg_writedata,
  input  logic                 reg_rd,
  input  logic                 reg_wr,
  output logic                 reg_ready,
  input  logic [aw-1:0]        reg_addr
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                    state, state_nx;
  logic [REG_NUM-1:0][31:0]  shadow;
  logic [aw-1:0]             base;
  logic [sw-1:0]             idx;
  logic [aw-1:0]             addr_a;
  logic                      wren_a, wren_b;
  logic                      collide;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (write_trigger) state_nx = WRITE;
      WRITE:   if (idx == sw'(REG_NUM-1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign write_busy = (state != IDLE);
  assign write_done = (state == DONE);

  // ---------------- datapath ----------------
  // shadow/base are not reset: they are only consumed after a trigger loads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      write_drop <= 1'b0;
      reg_ready  <= 1'b0;
    end else begin
      write_drop <= write_trigger && (state != IDLE);
      reg_ready  <= (reg_rd || reg_wr) ? !reg_ready : 1'b0;
      if (state == IDLE && write_trigger) begin
        shadow <= seq_reg;
        base   <= write_addr;
        idx    <= '0;
      end else if (state == WRITE) begin
        idx <= idx + sw'(1);
      end
    end
  end

  // Address wraps modulo 2^aw. A reset in a WRITE cycle also cancels that
  // cycle's word so an aborted snapshot stops cleanly at the reset edge.
  assign addr_a  = base + aw'(idx);
  assign wren_a  = (state == WRITE) && !rst;
  // Snapshot word wins a same-address collision; the AXI access still handshakes.
  assign collide = wren_a && (addr_a == reg_addr);
  assign wren_b  = reg_wr && reg_ready && !collide;

  generic_dpram #(
    .DW       (32),
    .AW       (aw),
    .PIPELINE (0)
  ) u_ram (
    .clk       (clk),
    .address_a (addr_a),
    .data_a    (shadow[idx]),
    .wren_a    (wren_a),
    .address_b (reg_addr),
    .data_b    (reg_writedata),
    .wren_b    (wren_b),
    .rden_b    (reg_rd),
    .q_b       (reg_readdata)
  );
endmodule

// File: tb/tb_reg2ram.sv
// Bench for reg2ram with REG_NUM=4, BUF_NUM=4 (16-word RAM, 4-bit addresses).
// A cycle-level behavioural model (snapshot described as "cycle k after the
// trigger writes word k-1") is compared on every negedge; directed sequences
// add literal expectations, then a randomized phase runs against the model.
module tb_reg2ram;
  localparam int RN = 4;
  localparam int BN = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic              clk;
  logic              rst;
  logic [RN*32-1:0]  seq_reg;
  logic [AW-1:0]     write_addr;
  logic              write_trigger;
  logic              write_busy, write_done, write_drop;
  logic [31:0]       reg_readdata, reg_writedata;
  logic              reg_rd, reg_wr, reg_ready;
  logic [AW-1:0]     reg_addr;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  reg2ram #(.REG_NUM(RN), .BUF_NUM(BN)) dut (
    .clk(clk), .rst(rst), .seq_reg(seq_reg), .write_addr(write_addr),
    .write_trigger(write_trigger), .write_busy(write_busy), .write_done(write_done),
    .write_drop(write_drop), .reg_readdata(reg_readdata), .reg_writedata(reg_writedata),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_ready(reg_ready), .reg_addr(reg_addr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_act;
  int          m_cnt;        // cycles since accepted trigger, 1..RN+1
  logic [3:0]  m_base;
  logic [31:0] m_shadow [RN];
  bit          m_drop, m_ready;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_rdata;
  bit          m_rknown;

  initial begin
    m_act = 0; m_cnt = 0; m_base = 0; m_drop = 0; m_ready = 0; m_rknown = 0; m_rdata = 0;
    for (int i = 0; i < DEPTH; i++) begin m_known[i] = 0; m_mem[i] = 0; end
    for (int i = 0; i < RN; i++) m_shadow[i] = 0;
  end

  always @(posedge clk) begin : model
    logic [3:0] aa;
    bit awe, bwe;
    awe = m_act && m_cnt >= 1 && m_cnt <= RN && !rst;
    aa  = m_base + 4'(m_cnt - 1);
    if (reg_rd) begin m_rdata = m_mem[reg_addr]; m_rknown = m_known[reg_addr]; end
    bwe = reg_wr && m_ready && !(awe && aa == reg_addr);
    if (awe) begin m_mem[aa] = m_shadow[m_cnt-1]; m_known[aa] = 1; end
    if (bwe) begin m_mem[reg_addr] = reg_writedata; m_known[reg_addr] = 1; end
    if (rst) begin
      m_act = 0; m_cnt = 0; m_drop = 0; m_ready = 0;
    end else begin
      m_drop  = write_trigger && m_act;
      m_ready = (reg_rd || reg_wr) ? !m_ready : 1'b0;
      if (m_act) begin
        if (m_cnt == RN + 1) begin m_act = 0; m_cnt = 0; end
        else m_cnt++;
      end else if (write_trigger) begin
        m_act = 1; m_cnt = 1; m_base = write_addr;
        for (int i = 0; i < RN; i++) m_shadow[i] = seq_reg[32*i +: 32];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, write_busy}, {31'b0, m_act});
      check("done", {31'b0, write_done}, {31'b0, (m_act && m_cnt == RN + 1)});
      check("drop", {31'b0, write_drop}, {31'b0, m_drop});
      check("ready", {31'b0, reg_ready}, {31'b0, m_ready});
      if (m_ready && reg_rd && m_rknown) check("readdata", reg_readdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_words(input logic [31:0] a, b, c, d);
    seq_reg = {d, c, b, a};
  endtask

  task automatic trig(input logic [3:0] addr);
    write_addr = addr; write_trigger = 1;
    tick();
    write_trigger = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (write_busy && n < 20) begin tick(); n++; end
    check("idle_wait", {31'b0, write_busy}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    reg_rd = 1; reg_addr = a;
    while (reg_ready !== 1'b1 && n < 8) begin tick(); n++; end
    check("rd_handshake", {31'b0, reg_ready}, 32'd1);
    d = reg_readdata;
    tick();
    reg_rd = 0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    reg_wr = 1; reg_addr = a; reg_writedata = d;
    while (reg_ready !== 1'b1 && n < 8) begin tick(); n++; end
    check("wr_handshake", {31'b0, reg_ready}, 32'd1);
    tick();
    reg_wr = 0;
  endtask

  task automatic expect_ram(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(name, d, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    int done_cnt;
    bit ax_busy, ax_seen;
    rst = 1; seq_reg = '0; write_addr = 0; write_trigger = 0;
    reg_writedata = 0; reg_rd = 0; reg_wr = 0; reg_addr = 0;
    tick(); tick();
    chk_en = 1;
    check("rst_busy",  {31'b0, write_busy}, 32'd0);
    check("rst_done",  {31'b0, write_done}, 32'd0);
    check("rst_drop",  {31'b0, write_drop}, 32'd0);
    check("rst_ready", {31'b0, reg_ready},  32'd0);
    rst = 0;
    tick();

    // Snapshot {1,2,3,4} at 8; source changes right after the trigger.
    set_words(1, 2, 3, 4);
    trig(4'd8);
    set_words(9, 9, 9, 9);
    for (int k = 1; k <= 6; k++) begin
      check("t1_busy", {31'b0, write_busy}, {31'b0, (k <= 5)});
      check("t1_done", {31'b0, write_done}, {31'b0, (k == 5)});
      tick();
    end
    for (int i = 0; i < 4; i++) expect_ram("t1_ram", 4'(8 + i), 32'(i + 1));

    // Drops while busy/done; RAM[0..3] must stay as preloaded.
    for (int i = 0; i < 4; i++) axi_write(4'(i), 32'h100 + 32'(i));
    set_words(5, 6, 7, 8);
    trig(4'd12);
    for (int c = 1; c <= 7; c++) begin
      check("t3_drop", {31'b0, write_drop}, {31'b0, (c == 3 || c == 6)});
      if (c == 7) check("t3_accept", {31'b0, write_busy}, 32'd1);
      write_trigger = (c == 2 || c == 5 || c == 6);
      write_addr    = (c == 6) ? 4'd4 : 4'd0;
      if (c == 6) set_words(32'h11, 32'h12, 32'h13, 32'h14);
      tick();
    end
    write_trigger = 0;
    wait_idle();
    for (int i = 0; i < 4; i++) expect_ram("t3_untouched", 4'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) expect_ram("t3_first", 4'(12 + i), 32'(i + 5));
    for (int i = 0; i < 4; i++) expect_ram("t3_third", 4'(4 + i), 32'h11 + 32'(i));

    // Address wrap 14,15,0,1.
    set_words(32'h21, 32'h22, 32'h23, 32'h24);
    trig(4'd14);
    for (int k = 1; k <= 5; k++) begin
      check("t4_done", {31'b0, write_done}, {31'b0, (k == 5)});
      tick();
    end
    expect_ram("t4_w0", 4'd14, 32'h21);
    expect_ram("t4_w1", 4'd15, 32'h22);
    expect_ram("t4_w2", 4'd0,  32'h23);
    expect_ram("t4_w3", 4'd1,  32'h24);

    // Reset during cycle T+3 aborts the snapshot.
    set_words(32'h31, 32'h32, 32'h33, 32'h34);
    trig(4'd8);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("t5_busy", {31'b0, write_busy}, 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (write_done) done_cnt++;
      tick();
    end
    check("t5_nodone", 32'(done_cnt), 32'd0);
    expect_ram("t5_r8",  4'd8,  32'h31);
    expect_ram("t5_r9",  4'd9,  32'h32);
    expect_ram("t5_r10", 4'd10, 32'd3);
    expect_ram("t5_r11", 4'd11, 32'd4);

    // Held read: ready toggles 0,1,0,1.
    reg_rd = 1; reg_addr = 4'd9;
    check("t6_rdy0", {31'b0, reg_ready}, 32'd0);
    tick();
    check("t6_rdy1", {31'b0, reg_ready}, 32'd1);
    check("t6_data1", reg_readdata, 32'h32);
    tick();
    check("t6_rdy2", {31'b0, reg_ready}, 32'd0);
    tick();
    check("t6_rdy3", {31'b0, reg_ready}, 32'd1);
    check("t6_data3", reg_readdata, 32'h32);
    tick();
    reg_rd = 0;
    tick();

    // Collision: AXI writes 0xAA to 10 in the same cycle the snapshot writes 3 there.
    set_words(1, 2, 3, 4);
    trig(4'd8);
    tick();
    reg_wr = 1; reg_addr = 4'd10; reg_writedata = 32'hAA;
    tick();
    check("t6_coll_ready", {31'b0, reg_ready}, 32'd1);
    tick();
    reg_wr = 0;
    wait_idle();
    expect_ram("t6_coll", 4'd10, 32'd3);

    // Randomized phase against the model.
    ax_busy = 0; ax_seen = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < RN; i++) seq_reg[32*i +: 32] = $urandom;
      write_trigger = ($urandom_range(0, 5) == 0);
      write_addr    = 4'($urandom_range(0, 15));
      rst           = ($urandom_range(0, 199) == 0);
      if (ax_busy) begin
        if (ax_seen) begin reg_rd = 0; reg_wr = 0; ax_busy = 0; ax_seen = 0; end
        else if (reg_ready) ax_seen = 1;
      end else if ($urandom_range(0, 2) == 0) begin
        ax_busy = 1;
        reg_addr = 4'($urandom_range(0, 15));
        reg_writedata = $urandom;
        if ($urandom_range(0, 1) == 0) reg_rd = 1; else reg_wr = 1;
      end
      tick();
    end
    rst = 0; reg_rd = 0; reg_wr = 0; write_trigger = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
